// File: rtl/buffer_mux_rr.sv
// Round-robin merge of NUM_CH valid/ready channels onto one registered output.
// Optional locked-packet stall timeout: define BUFMUX_TIMEOUT_EN.
module buffer_mux_rr #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 35,
    parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH-1:0]        in_more,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic                     next_ready,
    input  logic                     mem_full,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
`ifdef BUFMUX_TIMEOUT_EN
    output logic [CH_W-1:0]          out_ch,
    output logic                     timeout_err
`else
    output logic [CH_W-1:0]          out_ch
`endif
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state, state_nxt;
    logic [CH_W-1:0] ptr, ptr_nxt;
    logic [CH_W-1:0] lock_ch, lock_nxt;
    logic [CH_W-1:0] grant;
    logic            gnt_vld;
    logic            space;
    logic            xfer;
    logic            more;
    logic [DATA_W-1:0] word;

    function automatic logic [CH_W-1:0] inc_ch(input logic [CH_W-1:0] c);
        int n;
        n = int'(c) + 1;
        if (n >= NUM_CH) n = 0;
        return CH_W'(n);
    endfunction

`ifdef BUFMUX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] stall_cnt, cnt_nxt;
    logic             stall_inc;
    logic             tmo;
`endif

    // Grant, handshake and transfer decode
    always_comb begin : out_comb
        int idx;
        idx     = 0;
        grant   = lock_ch;
        gnt_vld = 1'b0;
        space   = !mem_full && (!out_valid || next_ready);
        if (state == LOCKED) begin
            grant   = lock_ch;
            gnt_vld = 1'b1;
        end else begin
            // Walk backwards so the channel closest to ptr wins
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                idx = int'(ptr) + k;
                if (idx >= NUM_CH) idx = idx - NUM_CH;
                if (in_valid[idx]) begin
                    grant   = CH_W'(idx);
                    gnt_vld = 1'b1;
                end
            end
        end
        in_ready = '0;
        if (space && gnt_vld) in_ready[grant] = 1'b1;
        xfer = space && gnt_vld && in_valid[grant];
        more = in_more[grant];
        word = in_data[grant*DATA_W +: DATA_W];
    end

    always_comb begin : next_comb
        state_nxt = state;
        ptr_nxt   = ptr;
        lock_nxt  = lock_ch;
`ifdef BUFMUX_TIMEOUT_EN
        stall_inc = (state == LOCKED) && !in_valid[lock_ch] && space;
        tmo       = stall_inc && (stall_cnt == CNT_W'(TIMEOUT - 1));
`endif
        unique case (state)
            IDLE: begin
                if (xfer) begin
                    if (more) begin
                        state_nxt = LOCKED;
                        lock_nxt  = grant;
                    end else begin
                        ptr_nxt = inc_ch(grant);
                    end
                end
            end
            LOCKED: begin
                if (xfer && !more) begin
                    state_nxt = IDLE;
                    ptr_nxt   = inc_ch(lock_ch);
                end
`ifdef BUFMUX_TIMEOUT_EN
                else if (tmo) begin
                    state_nxt = IDLE;
                    ptr_nxt   = inc_ch(lock_ch);
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
`ifdef BUFMUX_TIMEOUT_EN
        cnt_nxt = stall_cnt;
        if (state_nxt != LOCKED || xfer)
            cnt_nxt = '0;
        else if (stall_inc)
            cnt_nxt = stall_cnt + 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            lock_ch   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
`ifdef BUFMUX_TIMEOUT_EN
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            lock_ch <= lock_nxt;
            if (xfer) begin
                out_data  <= word;
                out_ch    <= grant;
                out_valid <= 1'b1;
            end else if (next_ready) begin
                out_valid <= 1'b0;
            end
`ifdef BUFMUX_TIMEOUT_EN
            stall_cnt   <= cnt_nxt;
            timeout_err <= tmo;
`endif
        end
    end

endmodule

// File: tb/tb_buffer_mux_rr.sv
// Directed bench for buffer_mux_rr (4 channels, 35-bit words).
// Timeout scenario is compiled in only with BUFMUX_TIMEOUT_EN.
module tb_buffer_mux_rr;

    localparam int NCH = 4;
    localparam int DW  = 35;

    logic            clk = 1'b0;
    logic            reset;
    logic [NCH*DW-1:0] in_data;
    logic [NCH-1:0]  in_valid;
    logic [NCH-1:0]  in_more;
    logic [NCH-1:0]  in_ready;
    logic            next_ready;
    logic            mem_full;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic [1:0]      out_ch;
`ifdef BUFMUX_TIMEOUT_EN
    logic            timeout_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    buffer_mux_rr #(
        .NUM_CH (NCH),
        .DATA_W (DW),
        .TIMEOUT(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_more    (in_more),
        .in_ready   (in_ready),
        .next_ready (next_ready),
        .mem_full   (mem_full),
        .out_data   (out_data),
        .out_valid  (out_valid),
`ifdef BUFMUX_TIMEOUT_EN
        .out_ch     (out_ch),
        .timeout_err(timeout_err)
`else
        .out_ch     (out_ch)
`endif
    );

    always #5 clk = ~clk;

    // Advance one edge, land 1ns after it
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic [DW-1:0] d,
                          input logic v, input logic m);
        in_data[i*DW +: DW] = d;
        in_valid[i] = v;
        in_more[i]  = m;
    endtask

    task automatic clr_all();
        in_valid = '0;
        in_more  = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        in_data    = '0;
        in_valid   = '0;
        in_more    = '0;
        next_ready = 1'b1;
        mem_full   = 1'b0;
        cyc();
        cyc();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if (out_data !== 35'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h want 0", out_data);
        end
        n_cmp++;
        if (out_ch !== 2'd0) begin
            n_err++;
            $display("FAIL reset_ch: got %0d want 0", out_ch);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 0000", in_ready);
        end
    endtask

    task automatic test_basic();
        set_ch(0, 35'h1_0000_0001, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (in_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL basic_ready: got %b want 0001", in_ready);
        end
        cyc();
        clr_all();
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 35'h1_0000_0001 || out_ch !== 2'd0) begin
            n_err++;
            $display("FAIL basic_out: got v=%b d=%h ch=%0d want v=1 d=100000001 ch=0",
                     out_valid, out_data, out_ch);
        end
        // ptr now 1: ch1 beats ch0
        set_ch(0, 35'h5, 1'b1, 1'b0);
        set_ch(1, 35'h6, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (in_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL basic_ptr: got %b want 0010", in_ready);
        end
        clr_all();
        cyc();
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 35'h1_0000_0001) begin
            n_err++;
            $display("FAIL basic_drain: got v=%b d=%h want v=0 d=100000001",
                     out_valid, out_data);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < NCH; i++) set_ch(i, DW'(256 + i), 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (in_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL rr_first: got %b want 0001", in_ready);
        end
        for (int k = 0; k < 6; k++) begin
            cyc();
            n_cmp++;
            if (out_valid !== 1'b1 || out_ch !== 2'(k % 4) ||
                out_data !== DW'(256 + k % 4)) begin
                n_err++;
                $display("FAIL rr_word%0d: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                         k, out_valid, out_ch, out_data, k % 4, 256 + k % 4);
            end
        end
        clr_all();
        cyc();
    endtask

    task automatic test_packet_lock();
        do_reset();
        set_ch(1, 35'h0_AAAA_0000, 1'b1, 1'b1);
        set_ch(2, 35'h0_BBBB_0000, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (in_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL lock_w0_ready: got %b want 0010", in_ready);
        end
        cyc();
        n_cmp++;
        if (out_ch !== 2'd1 || out_data !== 35'h0_AAAA_0000) begin
            n_err++;
            $display("FAIL lock_w0_out: got ch=%0d d=%h want ch=1 d=0AAAA0000",
                     out_ch, out_data);
        end
        in_valid[1] = 1'b0;
        for (int g = 0; g < 2; g++) begin
            #1;
            n_cmp++;
            if (in_ready !== 4'b0010) begin
                n_err++;
                $display("FAIL lock_gap%0d: got %b want 0010", g, in_ready);
            end
            cyc();
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL lock_gap_valid: got %b want 0", out_valid);
        end
        set_ch(1, 35'h0_AAAA_0001, 1'b1, 1'b1);
        cyc();
        n_cmp++;
        if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 35'h0_AAAA_0001) begin
            n_err++;
            $display("FAIL lock_w1: got v=%b ch=%0d d=%h want v=1 ch=1 d=0AAAA0001",
                     out_valid, out_ch, out_data);
        end
        set_ch(1, 35'h0_AAAA_0002, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (in_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL lock_w2_ready: got %b want 0010", in_ready);
        end
        cyc();
        n_cmp++;
        if (out_ch !== 2'd1 || out_data !== 35'h0_AAAA_0002) begin
            n_err++;
            $display("FAIL lock_w2: got ch=%0d d=%h want ch=1 d=0AAAA0002",
                     out_ch, out_data);
        end
        in_valid[1] = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 4'b0100) begin
            n_err++;
            $display("FAIL lock_release: got %b want 0100", in_ready);
        end
        cyc();
        n_cmp++;
        if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 35'h0_BBBB_0000) begin
            n_err++;
            $display("FAIL lock_ch2: got v=%b ch=%0d d=%h want v=1 ch=2 d=0BBBB0000",
                     out_valid, out_ch, out_data);
        end
        clr_all();
        cyc();
    endtask

    task automatic test_backpressure();
        // ptr is 3 here
        set_ch(3, 35'h7_1234_5678, 1'b1, 1'b0);
        cyc();
        set_ch(3, 35'h0, 1'b0, 1'b0);
        set_ch(0, 35'h2_2222_2222, 1'b1, 1'b0);
        next_ready = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL bp_stall_ready: got %b want 0000", in_ready);
        end
        cyc();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 35'h7_1234_5678 || out_ch !== 2'd3) begin
            n_err++;
            $display("FAIL bp_hold: got v=%b d=%h ch=%0d want v=1 d=712345678 ch=3",
                     out_valid, out_data, out_ch);
        end
        mem_full   = 1'b1;
        next_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL bp_full_ready: got %b want 0000", in_ready);
        end
        cyc();
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 35'h7_1234_5678) begin
            n_err++;
            $display("FAIL bp_full_drain: got v=%b d=%h want v=0 d=712345678",
                     out_valid, out_data);
        end
        cyc();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL bp_full_idle: got v=%b rdy=%b want v=0 rdy=0000",
                     out_valid, in_ready);
        end
        mem_full = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL bp_resume_ready: got %b want 0001", in_ready);
        end
        cyc();
        n_cmp++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 35'h2_2222_2222) begin
            n_err++;
            $display("FAIL bp_resume: got v=%b ch=%0d d=%h want v=1 ch=0 d=222222222",
                     out_valid, out_ch, out_data);
        end
        clr_all();
        cyc();
    endtask

    task automatic test_reset_mid_packet();
        // ptr is 1; only ch3 requests
        set_ch(3, 35'h3_0000_0003, 1'b1, 1'b1);
        cyc();
        n_cmp++;
        if (out_valid !== 1'b1 || out_ch !== 2'd3) begin
            n_err++;
            $display("FAIL rst_lock_out: got v=%b ch=%0d want v=1 ch=3", out_valid, out_ch);
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_async: got %b want 0", out_valid);
        end
        clr_all();
        cyc();
        reset = 1'b1;
        for (int i = 0; i < NCH; i++) set_ch(i, DW'(i), 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (in_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL rst_regrant: got %b want 0001", in_ready);
        end
        clr_all();
        cyc();
    endtask

`ifdef BUFMUX_TIMEOUT_EN
    task automatic test_timeout();
        // ptr is 0 after the reset above
        set_ch(2, 35'h2_0000_0002, 1'b1, 1'b1);
        #1;
        n_cmp++;
        if (in_ready !== 4'b0100) begin
            n_err++;
            $display("FAIL tmo_ready: got %b want 0100", in_ready);
        end
        cyc();
        clr_all();
        for (int k = 1; k <= 3; k++) begin
            cyc();
            n_cmp++;
            if (timeout_err !== 1'b0) begin
                n_err++;
                $display("FAIL tmo_early%0d: got %b want 0", k, timeout_err);
            end
        end
        cyc();
        n_cmp++;
        if (timeout_err !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_pulse: got %b want 1", timeout_err);
        end
        set_ch(0, 35'h10, 1'b1, 1'b0);
        set_ch(3, 35'h13, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (in_ready !== 4'b1000) begin
            n_err++;
            $display("FAIL tmo_next: got %b want 1000", in_ready);
        end
        cyc();
        n_cmp++;
        if (timeout_err !== 1'b0 || out_ch !== 2'd3 || out_data !== 35'h13) begin
            n_err++;
            $display("FAIL tmo_after: got err=%b ch=%0d d=%h want err=0 ch=3 d=13",
                     timeout_err, out_ch, out_data);
        end
        clr_all();
        cyc();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_reset_mid_packet();
`ifdef BUFMUX_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/buffer_mux_rr.md
Name: buffer_mux_rr

Overview:
Parametrised successor to the fixed 4-channel buffer mux. Merges NUM_CH producer channels onto one output stream toward the memory writer, using explicit per-channel valid/ready handshakes instead of zero-as-empty data. Grant passes round-robin, skips idle channels, and stays locked to one channel for the whole of a multi-word packet. Output is registered; it honours downstream next_ready and mem_full backpressure.

Parameters:
NUM_CH, 4, number of input channels (>=1)
DATA_W, 35, data word width
CH_W, $clog2(NUM_CH) min 1, width of channel index
TIMEOUT, 64, stall limit in cycles for a locked packet (used only with the optional feature)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
in_data  input  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
in_valid  input  NUM_CH  channel i presents a word
in_more  input  NUM_CH  1 = further words of the same packet follow this word
in_ready  output  NUM_CH  channel i word is accepted this cycle if valid
next_ready  input  1  downstream accepts out_data this cycle
mem_full  input  1  memory full; no new words accepted
out_data  output  DATA_W  registered output word
out_valid  output  1  out_data is valid
out_ch  output  CH_W  source channel of out_data
timeout_err  output  1  one-cycle pulse on a locked-packet timeout (present only with the macro)

Behaviour:
- Reset (reset=0, asynchronous): out_valid=0, out_data=0, out_ch=0, state=IDLE, ptr=0, lock_ch=0, timeout_err=0, stall counter=0. Asserting reset mid-packet discards the lock. Words already accepted are lost.
- space = !mem_full && (!out_valid || next_ready). The output stage is a single register with pass-through refill, so a word is accepted in the same cycle the held word drains.
- grant (combinational):
  - IDLE: first channel with in_valid=1, searched in order ptr, ptr+1, ..., wrapping modulo NUM_CH.
  - LOCKED: lock_ch, regardless of in_valid.
  - IDLE with no in_valid bits set: no grant.
- in_ready[i] = space && (i == grant) && a grant exists. All other bits are 0. in_ready is combinational and may depend on in_valid while IDLE.
- Transfer: in_valid[g] && in_ready[g]. On the next edge, out_data=in_data[g], out_ch=g, out_valid=1. Latency from input to output is 1 cycle.
- Drain: when out_valid && next_ready and there is no transfer, out_valid goes to 0. out_data and out_ch hold their last value.
- State transitions:
  - IDLE, transfer with in_more=1 -> LOCKED, lock_ch=g.
  - IDLE, transfer with in_more=0 -> stay IDLE, ptr=(g+1) mod NUM_CH.
  - LOCKED, transfer with in_more=0 -> IDLE, ptr=(lock_ch+1) mod NUM_CH.
  - LOCKED, transfer with in_more=1 -> stay LOCKED.
- While LOCKED, no other channel gets in_ready, even if the locked channel drops in_valid.
- mem_full=1 forces all in_ready=0. It does not clear or stall an already-registered out_valid word (next_ready alone governs the drain). It does not change state or ptr.
- ptr wrap: channel NUM_CH-1 -> 0. With NUM_CH=1, ptr stays 0 and grant is always 0.
- Simultaneous requests: only the granted channel is served. The others wait, with no ordering memory beyond ptr.
- Same-cycle drain and accept: the output register is overwritten with the new word and out_valid stays 1.

Optional Feature:
BUFMUX_TIMEOUT_EN
- Defined:
  - A stall counter runs while LOCKED and in_valid[lock_ch]=0. It clears on any transfer, and on leaving LOCKED.
  - When the counter reaches TIMEOUT, the block returns to IDLE, sets ptr=(lock_ch+1) mod NUM_CH, and pulses timeout_err for 1 cycle.
  - The rest of the packet is dropped.
  - Downstream stalls (next_ready=0, mem_full=1) do not count.
- Undefined: no counter and no timeout_err port. LOCKED persists indefinitely.

Test Plan:
- Basic path:
  - Stimulus: after reset release, ch0 valid with data 0x1_0000_0001, more=0; next_ready=1.
  - Expected: in_ready[0]=1 in the same cycle; next cycle out_valid=1, out_data=0x1_0000_0001, out_ch=0; ptr=1.
- Round-robin fairness:
  - Stimulus: all 4 channels hold in_valid with single-word packets; next_ready=1.
  - Expected: out_ch sequence 0,1,2,3,0,1; one word per cycle, no gaps.
- Packet lock:
  - Stimulus: ch1 sends 3 words with more=1,1,0; ch2 is valid throughout; ch1 drops valid for 2 cycles between words 1 and 2.
  - Expected: ch1 words arrive consecutively on out_ch=1; in_ready[2]=0 until after ch1's third word; then ch2 is granted.
- Backpressure:
  - Stimulus: out_valid=1 with next_ready=0; then mem_full=1 with next_ready=1.
  - Expected: out_data held and all in_ready=0 in the first phase. In the second phase the held word drains, out_valid=0, and no new accept occurs until mem_full=0.
- Reset mid-packet:
  - Stimulus: assert reset while LOCKED on ch3.
  - Expected: out_valid=0 immediately (asynchronous); after release, ch0 is granted first when all channels are valid.
- Timeout (BUFMUX_TIMEOUT_EN, TIMEOUT=4):
  - Stimulus: ch2 sends a word with more=1, then goes idle.
  - Expected: timeout_err pulses 4 cycles after the last transfer; ch3 is then granted.
